// File: rtl/prog_loader.sv
// Boot-time program loader: streams 2**ADDR_W bytes into program RAM while holding the CPU.
// Define PROG_LOADER_CHECKSUM_EN to append a trailing checksum byte and an ERR state.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`else
        S_DONE  = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready are both high;
    // in_valid outside an in_ready cycle is ignored and nothing is consumed.
    // The write address/data registers double as the capture buffer, so they naturally
    // hold their last value between writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    addr_d  = cnt_q;
                    wdata_d = in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
                // The counter parks at its maximum; it never wraps inside a load.
                if (cnt_q == CNT_MAX) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (in_valid) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_DONE;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_DONE, S_ERR: begin
`else
            S_DONE: begin
`endif
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            S_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                in_ready = 1'b1;
`endif
                busy = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: basic load, back-pressure, start while busy, reset mid-load,
// and (with PROG_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int wr_cnt    = 0;
    int next_addr = 0;
    int unsigned start_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every RAM write must match the next expected {addr,data}
    always @(negedge clk) begin : wr_monitor
        logic [31:0] e;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            e = (exp_q.size() > 0) ? {20'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check_eq("ram_write", {20'b0, mem_addr, mem_wdata}, e);
        end
    end

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b, input bit expect_wr);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
        if (expect_wr) begin
            exp_q.push_back({next_addr[ADDR_W-1:0], b});
            next_addr++;
        end
        @(posedge clk); #1;
    endtask

    task automatic finish_load(input logic [DATA_W-1:0] ck);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(ck, 1'b0);
`else
        in_data = ck;
`endif
    endtask

    task automatic wait_end(output int elapsed);
        int n = 0;
        @(negedge clk);
        while (!(done || err) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!(done || err)) check_eq("end_timeout", {31'b0, done | err}, 32'd1);
        elapsed = int'(cyc - start_cyc);
        @(posedge clk); #1;
    endtask

    logic [DATA_W-1:0] basic_bytes[16];
    logic [DATA_W-1:0] b, sum;
    int elapsed, wr_base;

    initial begin
        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  {31'b0, in_ready}, 32'd0);
        check_eq("rst_busy",      {31'b0, busy}, 32'd0);
        check_eq("rst_done",      {31'b0, done}, 32'd0);
        check_eq("rst_err",       {31'b0, err}, 32'd0);
        check_eq("rst_cpu_hold",  {31'b0, cpu_hold}, 32'd1);
        check_eq("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        check_eq("rst_mem_addr",  {28'b0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);

        // after release nothing happens without start, even with in_valid high
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_no_write", wr_cnt, 0);
        check_eq("idle_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("idle_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        in_valid = 1'b0;

        // basic load: 1E 2F E0 F0 then twelve 00, checksum 0x1D
        for (int i = 0; i < 16; i++) basic_bytes[i] = 8'h00;
        basic_bytes[0] = 8'h1E;
        basic_bytes[1] = 8'h2F;
        basic_bytes[2] = 8'hE0;
        basic_bytes[3] = 8'hF0;
        next_addr = 0;
        pulse_start();
        check_eq("load_busy",     {31'b0, busy}, 32'd1);
        check_eq("load_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) send_byte(basic_bytes[i], 1'b1);
        finish_load(8'h1D);
        wait_end(elapsed);
        // two cycles per byte plus one CHECK cycle
        check_eq("load_cycles",   elapsed, 33);
        check_eq("basic_done",    {31'b0, done}, 32'd1);
        check_eq("basic_cpu_run", {31'b0, cpu_hold}, 32'd0);
        check_eq("basic_busy",    {31'b0, busy}, 32'd0);
        check_eq("basic_err",     {31'b0, err}, 32'd0);
        check_eq("basic_writes",  wr_cnt, 16);
        check_eq("basic_pending", exp_q.size(), 0);
        check_eq("basic_addr_hold",  {28'b0, mem_addr}, 32'd15);
        check_eq("basic_wdata_hold", {24'b0, mem_wdata}, 32'd0);

        // restart from DONE, back-pressure after byte 3, start pulse at byte 5
        wr_base = wr_cnt;
        next_addr = 0;
        sum = '0;
        pulse_start();
        check_eq("restart_done",     {31'b0, done}, 32'd0);
        check_eq("restart_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check_eq("restart_busy",     {31'b0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", {31'b0, in_ready}, 32'd1);
                    check_eq("bp_no_write", {31'b0, mem_we}, 32'd0);
                    @(posedge clk); #1;
                end
            end
            if (i == 5) begin
                in_valid = 1'b0;
                pulse_start();
            end
            b = 8'(i * 19 + 7);
            sum = sum + b;
            send_byte(b, 1'b1);
        end
        finish_load(sum);
        wait_end(elapsed);
        check_eq("bp_done",    {31'b0, done}, 32'd1);
        check_eq("bp_writes",  wr_cnt - wr_base, 16);
        check_eq("bp_pending", exp_q.size(), 0);

        // reset right after byte 7 is accepted: no write to address 7
        wr_base = wr_cnt;
        next_addr = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), i < 7);
        rst = 1'b0;
        #1;
        check_eq("abort_mem_we",    {31'b0, mem_we}, 32'd0);
        check_eq("abort_busy",      {31'b0, busy}, 32'd0);
        check_eq("abort_cpu_hold",  {31'b0, cpu_hold}, 32'd1);
        check_eq("abort_in_ready",  {31'b0, in_ready}, 32'd0);
        check_eq("abort_mem_addr",  {28'b0, mem_addr}, 32'd0);
        check_eq("abort_mem_wdata", {24'b0, mem_wdata}, 32'd0);
        check_eq("abort_state",     {29'b0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_writes",   wr_cnt - wr_base, 7);
        check_eq("abort_pending",  exp_q.size(), 0);
        check_eq("abort_held",     {31'b0, cpu_hold}, 32'd1);
        check_eq("abort_idle_rdy", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
        // 16 x 0x11 sums to 0x110 -> 0x10 mod 256
        wr_base = wr_cnt;
        next_addr = 0;
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b1);
        send_byte(8'h10, 1'b0);
        wait_end(elapsed);
        check_eq("ck_ok_done",   {31'b0, done}, 32'd1);
        check_eq("ck_ok_err",    {31'b0, err}, 32'd0);
        check_eq("ck_ok_writes", wr_cnt - wr_base, 16);

        wr_base = wr_cnt;
        next_addr = 0;
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b1);
        send_byte(8'h11, 1'b0);
        wait_end(elapsed);
        check_eq("ck_bad_err",      {31'b0, err}, 32'd1);
        check_eq("ck_bad_done",     {31'b0, done}, 32'd0);
        check_eq("ck_bad_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check_eq("ck_bad_busy",     {31'b0, busy}, 32'd0);
        check_eq("ck_bad_writes",   wr_cnt - wr_base, 16);
        in_valid = 1'b0;
`endif

        // final report
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
